// File: rtl/output_port_fifo.sv
// output_port_fifo
// Transmit-side CPU output port. The CPU pushes words with a one-cycle Write
// strobe. They are buffered in a small circular FIFO and handed to an
// external consumer over a Valid/Ready handshake. A sticky Overflow flag
// records any write that arrived while the buffer was full.

module output_port_fifo #(
  parameter int WIDTH_DATA_LENGTH = 8,
  parameter int DEPTH             = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [WIDTH_DATA_LENGTH-1:0] Data,
  input  logic                         Write,
  input  logic                         ClearErr,
  output logic                         Full,
  output logic [$clog2(DEPTH):0]       Count,
  output logic                         Overflow,
  output logic [WIDTH_DATA_LENGTH-1:0] Output,
  output logic                         Valid,
  input  logic                         Ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is never reset; only the pointers and the count decide which
  // entries hold live data.
  logic [WIDTH_DATA_LENGTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic fullNow;
  logic validNow;
  logic doPush;
  logic doPop;
  logic dropWrite;

  // Status flags come from registered state only, so there is no
  // combinational path from Write or Ready to Valid or Full.
  always_comb begin
    fullNow  = (count_q == CNT_W'(DEPTH));
    validNow = (count_q != '0);
  end

  // Handshake decode. Full is judged before the edge, so a write into a full
  // buffer is dropped even when the consumer pops on the same edge.
  always_comb begin
    doPush    = Write && !fullNow;
    doPop     = validNow && Ready;
    dropWrite = Write && fullNow;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  // A dropped write takes priority over ClearErr on the same edge.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end

    unique case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (dropWrite) begin
      overflow_d = 1'b1;
    end else if (ClearErr) begin
      overflow_d = 1'b0;
    end
  end

  // Control state register; reset discards every buffered word at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Data storage write port; contents need no reset.
  always_ff @(posedge Clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= Data;
    end
  end

  // Output drive: head word while valid, zero otherwise. The head only
  // moves on a pop, so Output holds steady while Valid && !Ready.
  always_comb begin
    Full     = fullNow;
    Valid    = validNow;
    Count    = count_q;
    Overflow = overflow_q;
    Output   = validNow ? mem_q[rdPtr_q] : '0;
  end

endmodule
